ysyx_22041211_mem_arbiter: RTL and testbench

- Shares the single memory port between the IFU (instruction fetch, read-only) and the LSU (load/store driven by EXU outputs mem_wen/mem_wdata/alu_result).
- Round-robin arbitration with one outstanding transaction at a time.
- A per-transaction response timeout returns an error to the owner if the memory never responds.
- Sits between the IFU/LSU and the memory/SRAM model.

---
 rtl/ysyx_22041211_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_ysyx_22041211_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (read-only) and LSU, one transaction in flight.
// Latency: request seen in IDLE -> mem_req_o next cycle; gnt/rvalid pass through combinationally; per-transaction response timeout.
module ysyx_22041211_mem_arbiter #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_i,
    input  logic [ADDR_LEN-1:0]   ifu_addr_i,
    output logic                  ifu_gnt_o,
    output logic                  ifu_rvalid_o,
    output logic [DATA_LEN-1:0]   ifu_rdata_o,
    output logic                  ifu_err_o,

    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [ADDR_LEN-1:0]   lsu_addr_i,
    input  logic [DATA_LEN-1:0]   lsu_wdata_i,
    input  logic [DATA_LEN/8-1:0] lsu_wmask_i,
    output logic                  lsu_gnt_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_LEN-1:0]   lsu_rdata_o,
    output logic                  lsu_err_o,

    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_LEN-1:0]   mem_addr_o,
    output logic [DATA_LEN-1:0]   mem_wdata_o,
    output logic [DATA_LEN/8-1:0] mem_wmask_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_LEN-1:0]   mem_rdata_i,

    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RESP
    } state_t;

    localparam logic       OWN_IFU = 1'b0;
    localparam logic       OWN_LSU = 1'b1;
    localparam bit         TO_EN   = (TIMEOUT != 0);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic       owner, owner_nxt;
    logic       last_grant, last_grant_nxt;
    logic [7:0] to_cnt, to_cnt_nxt;

    logic       gnt;
    logic       resp_vld;
    logic       resp_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            to_cnt     <= 8'd0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            to_cnt     <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        to_cnt_nxt     = to_cnt;
        mem_req_o      = 1'b0;
        gnt            = 1'b0;
        resp_vld       = 1'b0;
        resp_err       = 1'b0;

        case (state)
            IDLE: begin
                // On a tie the requester that did not win last time goes next.
                if (ifu_req_i && lsu_req_i) begin
                    owner_nxt = ~last_grant;
                    state_nxt = REQ;
                end else if (ifu_req_i) begin
                    owner_nxt = OWN_IFU;
                    state_nxt = REQ;
                end else if (lsu_req_i) begin
                    owner_nxt = OWN_LSU;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_req_o = 1'b1;
                gnt       = mem_gnt_i;
                if (mem_gnt_i) begin
                    last_grant_nxt = owner;
                    to_cnt_nxt     = 8'd0;
                    state_nxt      = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                to_cnt_nxt = to_cnt + 8'd1;
                // A real response on the timeout cycle wins over the error.
                if (mem_rvalid_i) begin
                    resp_vld  = 1'b1;
                    state_nxt = IDLE;
                end else if (TO_EN && (to_cnt == TO_LAST)) begin
                    resp_vld  = 1'b1;
                    resp_err  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        if (mem_req_o) begin
            if (owner == OWN_LSU) begin
                mem_we_o    = lsu_we_i;
                mem_addr_o  = lsu_addr_i;
                mem_wdata_o = lsu_wdata_i;
                mem_wmask_o = lsu_wmask_i;
            end else begin
                mem_addr_o  = ifu_addr_i;
            end
        end
    end

    assign ifu_gnt_o    = gnt      & (owner == OWN_IFU);
    assign ifu_rvalid_o = resp_vld & (owner == OWN_IFU);
    assign ifu_err_o    = resp_err & (owner == OWN_IFU);
    assign ifu_rdata_o  = (ifu_rvalid_o && !resp_err) ? mem_rdata_i : '0;

    assign lsu_gnt_o    = gnt      & (owner == OWN_LSU);
    assign lsu_rvalid_o = resp_vld & (owner == OWN_LSU);
    assign lsu_err_o    = resp_err & (owner == OWN_LSU);
    assign lsu_rdata_o  = (lsu_rvalid_o && !resp_err) ? mem_rdata_i : '0;

    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter; drives at posedge+1, checks at posedge+2.
module tb_ysyx_22041211_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_i;
    logic [31:0] ifu_addr_i;
    logic        ifu_gnt_o, ifu_rvalid_o, ifu_err_o;
    logic [31:0] ifu_rdata_o;
    logic        lsu_req_i, lsu_we_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic [3:0]  lsu_wmask_i;
    logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wmask_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    int total = 0;
    int bad   = 0;
    int gnt_pulses;

    localparam logic [31:0] IFU_A = 32'h8000_0100;
    localparam logic [31:0] LSU_A = 32'h8000_2000;

    always #5 clk = ~clk;

    ysyx_22041211_mem_arbiter #(.ADDR_LEN(32), .DATA_LEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
        .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o), .ifu_err_o(ifu_err_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_wmask_i(lsu_wmask_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
    );

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One transaction with both requests held; memory grants and responds at once.
    task automatic tie_xact(input logic exp_lsu);
        chk1("tie_idle_busy", busy_o, 1'b0);
        cyc; mem_gnt_i = 1'b1; #1;
        chk1("tie_ifu_gnt", ifu_gnt_o, !exp_lsu);
        chk1("tie_lsu_gnt", lsu_gnt_o, exp_lsu);
        chk32("tie_addr", mem_addr_o, exp_lsu ? LSU_A : IFU_A);
        cyc; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        mem_rdata_i = exp_lsu ? 32'h0000_1111 : 32'h0000_2222; #1;
        chk1("tie_ifu_rvalid", ifu_rvalid_o, !exp_lsu);
        chk1("tie_lsu_rvalid", lsu_rvalid_o, exp_lsu);
        cyc; mem_rvalid_i = 1'b0; mem_rdata_i = '0; #1;
    endtask

    initial begin
        rst = 1'b1;
        ifu_req_i = 1'b0; ifu_addr_i = '0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0; lsu_wmask_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (2) cyc;
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_mem_req", mem_req_o, 1'b0);
        chk32("rst_mem_addr", mem_addr_o, 32'h0);
        chk1("rst_ifu_gnt", ifu_gnt_o, 1'b0);
        chk1("rst_lsu_rvalid", lsu_rvalid_o, 1'b0);

        // IFU-only fetch
        rst = 1'b0; ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0000; #1;
        chk1("ifu_idle_mem_req", mem_req_o, 1'b0);
        cyc; mem_gnt_i = 1'b1; #1;
        chk1("ifu_mem_req", mem_req_o, 1'b1);
        chk32("ifu_mem_addr", mem_addr_o, 32'h8000_0000);
        chk1("ifu_mem_we", mem_we_o, 1'b0);
        chk1("ifu_gnt", ifu_gnt_o, 1'b1);
        chk1("ifu_lsu_gnt", lsu_gnt_o, 1'b0);
        cyc; ifu_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
        chk1("ifu_w1_mem_req", mem_req_o, 1'b0);
        chk1("ifu_w1_rvalid", ifu_rvalid_o, 1'b0);
        cyc; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0413; #1;
        chk1("ifu_rvalid", ifu_rvalid_o, 1'b1);
        chk32("ifu_rdata", ifu_rdata_o, 32'h0000_0413);
        chk1("ifu_err", ifu_err_o, 1'b0);
        chk1("ifu_lsu_rvalid", lsu_rvalid_o, 1'b0);
        chk32("ifu_lsu_rdata", lsu_rdata_o, 32'h0);
        cyc; mem_rvalid_i = 1'b0; mem_rdata_i = '0; #1;
        chk1("ifu_done_busy", busy_o, 1'b0);

        // LSU store
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h8000_1000;
        lsu_wdata_i = 32'hDEAD_BEEF; lsu_wmask_i = 4'hF; #1;
        cyc; #1;
        chk1("st_mem_we", mem_we_o, 1'b1);
        chk32("st_mem_addr", mem_addr_o, 32'h8000_1000);
        chk32("st_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk32("st_mem_wmask", {28'h0, mem_wmask_o}, 32'hF);
        mem_gnt_i = 1'b1; #1;
        chk1("st_lsu_gnt", lsu_gnt_o, 1'b1);
        chk1("st_ifu_gnt", ifu_gnt_o, 1'b0);
        cyc; lsu_req_i = 1'b0; lsu_we_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; #1;
        chk1("st_lsu_rvalid", lsu_rvalid_o, 1'b1);
        chk1("st_lsu_err", lsu_err_o, 1'b0);
        chk1("st_ifu_rvalid", ifu_rvalid_o, 1'b0);
        cyc; mem_rvalid_i = 1'b0; #1;

        // IFU timeout: TIMEOUT=4 -> error on the 4th WAIT_RESP cycle
        ifu_req_i = 1'b1; ifu_addr_i = IFU_A; #1;
        cyc; mem_gnt_i = 1'b1; #1;
        chk1("to_ifu_gnt", ifu_gnt_o, 1'b1);
        cyc; ifu_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
        chk1("to_w1_rvalid", ifu_rvalid_o, 1'b0);
        cyc; cyc; #1;
        chk1("to_w3_rvalid", ifu_rvalid_o, 1'b0);
        chk1("to_w3_busy", busy_o, 1'b1);
        cyc; #1;
        chk1("to_w4_rvalid", ifu_rvalid_o, 1'b1);
        chk1("to_w4_err", ifu_err_o, 1'b1);
        chk32("to_w4_rdata", ifu_rdata_o, 32'h0);
        chk1("to_w4_lsu_err", lsu_err_o, 1'b0);
        cyc; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_AAAA; #1;
        chk1("stray_busy", busy_o, 1'b0);
        chk1("stray_ifu_rvalid", ifu_rvalid_o, 1'b0);
        chk32("stray_ifu_rdata", ifu_rdata_o, 32'h0);
        chk1("stray_lsu_rvalid", lsu_rvalid_o, 1'b0);
        cyc; mem_rvalid_i = 1'b0; mem_rdata_i = '0; #1;

        // LSU read whose response lands exactly on the timeout cycle
        lsu_req_i = 1'b1; lsu_addr_i = LSU_A; #1;
        cyc; mem_gnt_i = 1'b1; #1;
        chk1("prec_lsu_gnt", lsu_gnt_o, 1'b1);
        cyc; lsu_req_i = 1'b0; mem_gnt_i = 1'b0;
        cyc; cyc; cyc; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_5555; #1;
        chk1("prec_lsu_rvalid", lsu_rvalid_o, 1'b1);
        chk1("prec_lsu_err", lsu_err_o, 1'b0);
        chk32("prec_lsu_rdata", lsu_rdata_o, 32'h0000_5555);
        cyc; mem_rvalid_i = 1'b0; mem_rdata_i = '0; #1;

        // Reset in WAIT_RESP after an LSU grant; late response must be dropped
        lsu_req_i = 1'b1; #1;
        cyc; mem_gnt_i = 1'b1; #1;
        cyc; lsu_req_i = 1'b0; mem_gnt_i = 1'b0; rst = 1'b1; #1;
        chk1("rst_mid_busy_before", busy_o, 1'b1);
        cyc; rst = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0077; #1;
        chk1("rst_mid_busy", busy_o, 1'b0);
        chk1("rst_mid_lsu_rvalid", lsu_rvalid_o, 1'b0);
        chk32("rst_mid_lsu_rdata", lsu_rdata_o, 32'h0);
        chk1("rst_mid_mem_req", mem_req_o, 1'b0);
        mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        ifu_req_i = 1'b1; ifu_addr_i = IFU_A;
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = LSU_A; #1;

        // Tie after reset: LSU, IFU, LSU, IFU
        tie_xact(1'b1);
        tie_xact(1'b0);
        tie_xact(1'b1);
        ifu_req_i = 1'b1;
        tie_xact(1'b0);
        ifu_req_i = 1'b0; lsu_req_i = 1'b0;
        cyc; cyc; #1;
        chk1("post_tie_busy", busy_o, 1'b0);

        // Slow grant: memory withholds gnt for 5 REQ cycles
        ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0200; #1;
        gnt_pulses = 0;
        for (int i = 0; i < 5; i++) begin
            cyc; #1;
            chk1("slow_mem_req", mem_req_o, 1'b1);
            chk32("slow_mem_addr", mem_addr_o, 32'h8000_0200);
            if (ifu_gnt_o) gnt_pulses++;
        end
        mem_gnt_i = 1'b1; #1;
        if (ifu_gnt_o) gnt_pulses++;
        cyc; ifu_req_i = 1'b0; mem_gnt_i = 1'b0; #1;
        if (ifu_gnt_o) gnt_pulses++;
        chk32("slow_gnt_pulses", 32'(gnt_pulses), 32'd1);
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678; #1;
        chk32("slow_rdata", ifu_rdata_o, 32'h1234_5678);
        cyc; mem_rvalid_i = 1'b0; #1;
        chk1("slow_done_busy", busy_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
